// File: rtl/benes_route_sequencer.sv
// benes_route_sequencer: issues runs of precomputed Benes switch settings
// from a register table onto the interconnect select inputs. It also
// delays the issue strobe/index by NET_LATENCY so that they line up with
// data at the interconnect output registers.
// Optional stall counter: define BENES_SEQ_STALL_CNT_EN.
module benes_route_sequencer #(
    parameter int PORT_NUM    = 32,
    parameter int SWITCH_NUM  = PORT_NUM / 2,
    parameter int STAGE_NUM   = 2 * $clog2(PORT_NUM) - 1,
    parameter int CFG_DEPTH   = 16,
    parameter int CFG_AW      = $clog2(CFG_DEPTH),
    parameter int NET_LATENCY = 10,
    parameter int CNT_W       = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            I_CFG_WE,
    input  logic [CFG_AW-1:0]               I_CFG_ADDR,
    input  logic [STAGE_NUM*SWITCH_NUM-1:0] I_CFG_MODULE_SELECT,
    input  logic [STAGE_NUM*SWITCH_NUM-1:0] I_CFG_SLOT_SELECT,
    input  logic                            I_CMD_VALID,
    output logic                            O_CMD_READY,
    input  logic [CFG_AW-1:0]               I_CMD_BASE,
    input  logic [CFG_AW:0]                 I_CMD_LEN,
    input  logic                            I_ISSUE_EN,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] O_MODULE_SELECT,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] O_SLOT_SELECT,
    output logic                            O_ISSUE_VALID,
    output logic [CFG_AW-1:0]               O_ISSUE_IDX,
    output logic                            O_RESULT_VALID,
    output logic [CFG_AW-1:0]               O_RESULT_IDX,
    output logic                            O_BUSY,
    output logic                            O_DONE,
    output logic [CNT_W-1:0]                O_STALL_CNT
);

    localparam int SEL_W = STAGE_NUM * SWITCH_NUM;
    // Selects the delay stages that still feed a future result; the last
    // stage is the result register itself.
    localparam logic [NET_LATENCY-1:0] INNER_MASK = {NET_LATENCY{1'b1}} >> 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [SEL_W-1:0]       cfg_module [CFG_DEPTH];
    logic [SEL_W-1:0]       cfg_slot   [CFG_DEPTH];
    logic [CFG_AW-1:0]      addr, rd_addr;
    logic [CFG_AW:0]        rem, rd_rem;
    logic                   accept, fire, pending;
    logic [NET_LATENCY-1:0] pipe_v;
    logic [CFG_AW-1:0]      pipe_idx [NET_LATENCY];

    // Issue decision: on accept the command fields are used directly so the
    // first entry goes out on the accept edge.
    always_comb begin
        accept  = I_CMD_VALID && (state == S_IDLE);
        rd_addr = accept ? I_CMD_BASE : addr;
        rd_rem  = accept ? I_CMD_LEN : rem;
        fire    = I_ISSUE_EN && (accept || (state == S_ISSUE)) && (rd_rem != '0);
        pending = O_ISSUE_VALID || (|(pipe_v & INNER_MASK));
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and status outputs. A one-entry command issued on the
    // accept edge has already exhausted rem, so it heads straight to DRAIN.
    always_comb begin
        state_nxt   = state;
        O_CMD_READY = 1'b0;
        O_BUSY      = 1'b1;
        O_DONE      = 1'b0;
        case (state)
            S_IDLE: begin
                O_CMD_READY = 1'b1;
                O_BUSY      = 1'b0;
                if (accept) begin
                    if ((I_CMD_LEN == '0) || (fire && (I_CMD_LEN == (CFG_AW+1)'(1))))
                        state_nxt = S_DRAIN;
                    else
                        state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: if (fire && (rem == (CFG_AW+1)'(1))) state_nxt = S_DRAIN;
            S_DRAIN: if (!pending) state_nxt = S_DONE;
            S_DONE: begin
                O_DONE    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Configuration table writes; contents survive reset.
    always_ff @(posedge CLK) begin
        if (I_CFG_WE) begin
            cfg_module[I_CFG_ADDR] <= I_CFG_MODULE_SELECT;
            cfg_slot[I_CFG_ADDR]   <= I_CFG_SLOT_SELECT;
        end
    end

    // Command pointer, remaining count and issue registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr            <= '0;
            rem             <= '0;
            O_ISSUE_VALID   <= 1'b0;
            O_ISSUE_IDX     <= '0;
            O_MODULE_SELECT <= '0;
            O_SLOT_SELECT   <= '0;
        end else begin
            O_ISSUE_VALID <= fire;
            if (accept) begin
                addr <= I_CMD_BASE;
                rem  <= I_CMD_LEN;
            end
            if (fire) begin
                O_MODULE_SELECT <= cfg_module[rd_addr];
                O_SLOT_SELECT   <= cfg_slot[rd_addr];
                O_ISSUE_IDX     <= rd_addr;
                addr            <= rd_addr + CFG_AW'(1);
                rem             <= rd_rem - (CFG_AW+1)'(1);
            end
        end
    end

    // Latency-matching delay line for the issue strobe and index.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < NET_LATENCY; i++) pipe_idx[i] <= '0;
        end else begin
            pipe_v[0]   <= O_ISSUE_VALID;
            pipe_idx[0] <= O_ISSUE_IDX;
            for (int unsigned i = 1; i < NET_LATENCY; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    assign O_RESULT_VALID = pipe_v[NET_LATENCY-1];
    assign O_RESULT_IDX   = pipe_idx[NET_LATENCY-1];

`ifdef BENES_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of cycles an issue was pending but not permitted.
    always_ff @(posedge CLK) begin
        if (RST || accept)
            stall_cnt <= '0;
        else if ((state == S_ISSUE) && (rem != '0) && !I_ISSUE_EN && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign O_STALL_CNT = stall_cnt;
`else
    assign O_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Self-checking bench for benes_route_sequencer: directed command table,
// hand-written corner sequences and randomized traffic, all checked every
// cycle against a transaction-level reference model.
module tb_benes_route_sequencer;

    localparam int PN    = 32;
    localparam int SEL_W = (2 * $clog2(PN) - 1) * (PN / 2);
    localparam int DEP   = 16;
    localparam int AW    = 4;
    localparam int NL    = 10;
    localparam int CW    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we = 1'b0;
    logic [AW-1:0]    waddr = '0;
    logic [SEL_W-1:0] wm = '0, ws = '0;
    logic             vld = 1'b0;
    logic [AW-1:0]    base = '0;
    logic [AW:0]      len = '0;
    logic             en = 1'b0;

    logic             ready, iv, rv, busy, done;
    logic [SEL_W-1:0] msel, ssel;
    logic [AW-1:0]    idx, ridx;
    logic [CW-1:0]    stall;

    benes_route_sequencer #(
        .PORT_NUM(PN), .CFG_DEPTH(DEP), .NET_LATENCY(NL), .CNT_W(CW)
    ) dut (
        .CLK(clk), .RST(rst),
        .I_CFG_WE(we), .I_CFG_ADDR(waddr),
        .I_CFG_MODULE_SELECT(wm), .I_CFG_SLOT_SELECT(ws),
        .I_CMD_VALID(vld), .O_CMD_READY(ready),
        .I_CMD_BASE(base), .I_CMD_LEN(len), .I_ISSUE_EN(en),
        .O_MODULE_SELECT(msel), .O_SLOT_SELECT(ssel),
        .O_ISSUE_VALID(iv), .O_ISSUE_IDX(idx),
        .O_RESULT_VALID(rv), .O_RESULT_IDX(ridx),
        .O_BUSY(busy), .O_DONE(done), .O_STALL_CNT(stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    logic [SEL_W-1:0] mm [DEP];
    logic [SEL_W-1:0] ms [DEP];
    bit               m_busy = 0;
    int               m_addr = 0, m_rem = 0, m_stall = 0, m_issued = 0;
    int               m_last = 0, m_acc = 0, m_done_at = -1;
    bit               hist_v [16];
    logic [AW-1:0]    hist_i [16];
    bit               e_iv = 0, e_rv = 0, e_done = 0, e_busy = 0;
    logic [AW-1:0]    e_idx = '0, e_ridx = '0;
    logic [SEL_W-1:0] e_msel = '0, e_ssel = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [SEL_W-1:0] rand_sel();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[SEL_W-1:0];
    endfunction

    // One clock: predict the post-edge outputs, clock, then compare.
    task automatic step();
        int t;
        bit acc, fire;
        t = cyc + 1;
        if (rst) begin
            m_busy = 0; m_rem = 0; m_stall = 0; m_done_at = -1; m_issued = 0;
            e_iv = 0; e_rv = 0; e_done = 0; e_busy = 0;
            e_idx = '0; e_ridx = '0; e_msel = '0; e_ssel = '0;
            for (int i = 0; i < 16; i++) begin hist_v[i] = 0; hist_i[i] = '0; end
        end else begin
            if (m_busy && m_done_at >= 0 && cyc > m_done_at) m_busy = 0;
            acc = vld && !m_busy;
            if (m_busy && m_rem > 0 && !en && m_stall < (1 << CW) - 1) m_stall++;
            if (acc) begin
                m_busy = 1; m_addr = int'(base); m_rem = int'(len);
                m_stall = 0; m_issued = 0; m_acc = cyc; m_done_at = -1;
            end
            fire = en && m_busy && m_rem > 0;
            e_iv = fire;
            if (fire) begin
                e_idx  = AW'(m_addr);
                e_msel = mm[m_addr];
                e_ssel = ms[m_addr];
                m_addr = (m_addr + 1) % DEP;
                m_rem--;
                m_issued++;
                m_last = t;
            end
            if (m_busy && m_rem == 0 && m_done_at < 0)
                m_done_at = (m_issued > 0) ? m_last + NL + 1 : m_acc + 2;
            e_done = (t == m_done_at);
            e_busy = m_busy && !(m_done_at >= 0 && t > m_done_at);
            e_rv   = hist_v[(t + 16 - NL) % 16];
            e_ridx = hist_i[(t + 16 - NL) % 16];
            hist_v[t % 16] = e_iv;
            hist_i[t % 16] = e_idx;
        end
        if (we) begin mm[waddr] = wm; ms[waddr] = ws; end
        @(posedge clk);
        #1;
        cyc++;
        chk("ready",  256'(ready), 256'(!e_busy));
        chk("busy",   256'(busy),  256'(e_busy));
        chk("done",   256'(done),  256'(e_done));
        chk("iv",     256'(iv),    256'(e_iv));
        chk("idx",    256'(idx),   256'(e_idx));
        chk("msel",   256'(msel),  256'(e_msel));
        chk("ssel",   256'(ssel),  256'(e_ssel));
        chk("rv",     256'(rv),    256'(e_rv));
        chk("ridx",   256'(ridx),  256'(e_ridx));
`ifdef BENES_SEQ_STALL_CNT_EN
        chk("stall",  256'(stall), 256'(m_stall));
`else
        chk("stall",  256'(stall), 256'(0));
`endif
    endtask

    // Idle until O_DONE with issue permitted; bounded.
    task automatic wait_done(input int budget);
        int k;
        k = 0;
        vld = 0; en = 1; we = 0;
        while (!done && k < budget) begin step(); k++; end
        chk("wait_done_seen", 256'(done), 256'(1));
    endtask

    typedef struct {
        int base;
        int len;
        int gap;
        int exp_done;
        int exp_issues;
        int exp_stall;
    } vec_t;

    vec_t tv [6];

    initial begin
        int r, issues, done_off;
        logic [SEL_W-1:0] old_m, new_m;

        tv[0] = '{base: 0,  len: 4,  gap: 0, exp_done: 15, exp_issues: 4,  exp_stall: 0};
        tv[1] = '{base: 14, len: 4,  gap: 0, exp_done: 15, exp_issues: 4,  exp_stall: 0};
        tv[2] = '{base: 0,  len: 3,  gap: 2, exp_done: 16, exp_issues: 3,  exp_stall: 2};
        tv[3] = '{base: 5,  len: 0,  gap: 0, exp_done: 2,  exp_issues: 0,  exp_stall: 0};
        tv[4] = '{base: 3,  len: 16, gap: 0, exp_done: 27, exp_issues: 16, exp_stall: 0};
        tv[5] = '{base: 7,  len: 1,  gap: 0, exp_done: 12, exp_issues: 1,  exp_stall: 0};

        // Reset, then fill the table with distinct patterns
        rst = 1; step(); step();
        rst = 0;
        for (int a = 0; a < DEP; a++) begin
            we = 1; waddr = AW'(a); wm = rand_sel(); ws = rand_sel();
            step();
        end
        we = 0;

        // Directed command table
        for (int i = 0; i < 6; i++) begin
            vld = 1; en = 1; base = AW'(tv[i].base); len = (AW+1)'(tv[i].len);
            step();
            vld = 0;
            r = 1;
            issues = iv ? 1 : 0;
            done_off = done ? 1 : -1;
            while (done_off < 0 && r < 200) begin
                en = (r <= tv[i].gap) ? 1'b0 : 1'b1;
                step();
                r++;
                if (iv) issues++;
                if (done) done_off = r;
            end
            chk("tbl_done_cycle", 256'(done_off), 256'(tv[i].exp_done));
            chk("tbl_issue_count", 256'(issues), 256'(tv[i].exp_issues));
`ifdef BENES_SEQ_STALL_CNT_EN
            chk("tbl_stall", 256'(stall), 256'(tv[i].exp_stall));
`else
            chk("tbl_stall", 256'(stall), 256'(0));
`endif
            en = 1;
            step();
            chk("tbl_ready_after", 256'(ready), 256'(1));
        end

        // Write to entry 1 on the edge that issues it: old data goes out
        old_m = mm[1];
        new_m = ~old_m;
        vld = 1; en = 1; base = 0; len = 3;
        step();
        vld = 0;
        we = 1; waddr = 1; wm = new_m; ws = ~ms[1];
        step();
        we = 0;
        chk("coll_idx", 256'(idx), 256'(1));
        chk("coll_old_data", 256'(msel), 256'(old_m));
        wait_done(100);
        step();
        vld = 1; base = 1; len = 1;
        step();
        vld = 0;
        chk("coll_new_data", 256'(msel), 256'(new_m));
        wait_done(100);
        step();

        // Reset after two of five issues
        vld = 1; en = 1; base = 4; len = 5;
        step();
        vld = 0;
        step();
        chk("rst_pre_idx", 256'(idx), 256'(5));
        rst = 1;
        step();
        rst = 0;
        chk("rst_iv",    256'(iv),    256'(0));
        chk("rst_msel",  256'(msel),  256'(0));
        chk("rst_ready", 256'(ready), 256'(1));
        for (int k = 0; k < 15; k++) begin
            step();
            chk("rst_no_result", 256'(rv),   256'(0));
            chk("rst_no_done",   256'(done), 256'(0));
        end

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
            vld   = ($urandom % 4) == 0;
            base  = AW'($urandom_range(0, DEP - 1));
            len   = (AW+1)'($urandom_range(0, DEP));
            en    = ($urandom % 4) != 0;
            we    = ($urandom % 5) == 0;
            waddr = AW'($urandom_range(0, DEP - 1));
            wm    = rand_sel();
            ws    = rand_sel();
            step();
        end
        vld = 0; we = 0; en = 1;
        for (int k = 0; k < 40; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/benes_route_sequencer.md
Name: benes_route_sequencer

Overview:
- Control-side initiator for the packed Benes RAM<->module interconnect.
- Holds a small table of precomputed switch configurations: module-select for the RAM-to-module network, slot-select for the module-to-RAM network.
- On command, issues a run of table entries onto the interconnect select inputs, one per enabled cycle.
- Tracks network latency and emits a result-valid/index strobe aligned with data at the interconnect output registers.

Parameters:
- PORT_NUM, 32, interconnect port count.
- SWITCH_NUM, PORT_NUM/2, 2x2 switches per stage.
- STAGE_NUM, 2*$clog2(PORT_NUM)-1, Benes stages.
- CFG_DEPTH, 16, configuration table entries (power of two).
- CFG_AW, $clog2(CFG_DEPTH), table address width.
- NET_LATENCY, 10, cycles from select/data presented at the interconnect inputs to valid data at its outputs (>=1).
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- I_CFG_WE  in  1  table write enable.
- I_CFG_ADDR  in  CFG_AW  table write address.
- I_CFG_MODULE_SELECT  in  STAGE_NUM*SWITCH_NUM  module-select entry data.
- I_CFG_SLOT_SELECT  in  STAGE_NUM*SWITCH_NUM  slot-select entry data.
- I_CMD_VALID  in  1  command valid.
- O_CMD_READY  out  1  command ready (high only in IDLE).
- I_CMD_BASE  in  CFG_AW  first table entry.
- I_CMD_LEN  in  CFG_AW+1  entries to issue, 0..CFG_DEPTH.
- I_ISSUE_EN  in  1  downstream permits issue this cycle (RAM/module data ready).
- O_MODULE_SELECT  out  STAGE_NUM*SWITCH_NUM  to interconnect I_MODULE_SELECT.
- O_SLOT_SELECT  out  STAGE_NUM*SWITCH_NUM  to interconnect I_SLOT_SELECT.
- O_ISSUE_VALID  out  1  selects hold a newly issued entry this cycle.
- O_ISSUE_IDX  out  CFG_AW  table index being issued.
- O_RESULT_VALID  out  1  O_ISSUE_VALID delayed NET_LATENCY cycles.
- O_RESULT_IDX  out  CFG_AW  O_ISSUE_IDX delayed NET_LATENCY cycles.
- O_BUSY  out  1  state != IDLE.
- O_DONE  out  1  one-cycle pulse at end of command.
- O_STALL_CNT  out  CNT_W  stall counter (optional feature).

Behaviour:
- Reset: state IDLE. All outputs 0 except O_CMD_READY=1. Delay line cleared. Table contents not reset.
- Table is a register array. A write lands at the clock edge; an issue read in the same cycle as a write to the same address returns the old contents.
- Accept: I_CMD_VALID & O_CMD_READY. Latch addr=I_CMD_BASE, rem=I_CMD_LEN.
- Issue edge: occurs when (accepting with LEN>0, or state ISSUE with rem>0) and I_ISSUE_EN=1. At that edge:
  - selects <= cfg[addr]; O_ISSUE_IDX <= addr; O_ISSUE_VALID <= 1.
  - addr <= addr+1, wrapping mod CFG_DEPTH; rem <= rem-1.
- Any other edge: O_ISSUE_VALID <= 0. Selects and O_ISSUE_IDX hold their last values.
- FSM:
  - IDLE -> ISSUE on accept with LEN>0.
  - IDLE -> DRAIN on accept with LEN=0.
  - ISSUE -> DRAIN on the edge where rem reaches 0.
  - DRAIN -> DONE when the delay line holds no valid and O_ISSUE_VALID=0.
  - DONE: O_DONE=1 for one cycle -> IDLE.
- Latency: first O_ISSUE_VALID appears the cycle after acceptance if I_ISSUE_EN=1. O_RESULT_VALID follows exactly NET_LATENCY cycles after each O_ISSUE_VALID.
- I_ISSUE_EN low in ISSUE: bubble cycle, no index skipped, results keep their order.
- LEN=CFG_DEPTH issues every entry once, starting at BASE and wrapping.
- RST asserted mid-command: abort immediately, clear the delay line, return to IDLE, no O_DONE.
- I_CMD_VALID outside IDLE is ignored (READY=0).

Optional Feature:
- Macro BENES_SEQ_STALL_CNT_EN.
- Defined: O_STALL_CNT counts cycles in ISSUE with rem>0 and I_ISSUE_EN=0. Cleared on command accept and on reset. Saturates at 2^CNT_W-1. Holds its value after the command ends.
- Undefined: O_STALL_CNT tied to 0 and no counter logic is present.

Test Plan:
- Write entries 0..3 with distinct patterns; cmd BASE=0 LEN=4, I_ISSUE_EN=1 -> ISSUE_VALID cycles 1-4 with IDX 0,1,2,3 and matching selects; RESULT_VALID cycles 11-14 (NET_LATENCY=10); O_DONE cycle 15; READY=1 cycle 16.
- BASE=14 LEN=4 -> IDX 14,15,0,1 (wrap).
- LEN=3, I_ISSUE_EN low for 2 cycles after the first issue -> IDX 0 then gap of 2 then 1,2; RESULT gaps identical; STALL_CNT=2 with macro, 0 without.
- LEN=0 -> no ISSUE_VALID/RESULT_VALID; O_DONE 2 cycles after accept.
- Write addr 1 in the same cycle entry 1 is issued -> old data issued; rerun issues new data.
- RST during ISSUE after 2 of 5 issues -> outputs 0, READY=1 next cycle, no DONE, no further RESULT_VALID.
